// File: rtl/multi_cycle_controller_pkg.sv
// Shared state, opcode and control-field encodings for the multi-cycle controller.
package multi_cycle_controller_pkg;

    localparam int unsigned OP_W    = 7;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE_R = 4'd6,
        S_EXECUTE_I = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BEQ       = 4'd9,
        S_JAL       = 4'd10
    } state_t;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

    localparam logic ADR_PC  = 1'b0;
    localparam logic ADR_ALU = 1'b1;

    localparam logic [SEL_W-1:0] SRC_A_PC     = 2'b00;
    localparam logic [SEL_W-1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [SEL_W-1:0] SRC_A_RS1    = 2'b10;

    localparam logic [SEL_W-1:0] SRC_B_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRC_B_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRC_B_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALU_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALU_OUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_READ_DATA  = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALU_RESULT = 2'b10;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic             mem_req;
        logic             adr_src;
        logic             ir_write;
        logic             pc_write;
        logic             reg_write;
        logic             mem_write;
        logic             instr_done;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] result_src;
    } ctrl_t;

    // Immediate format follows the opcode alone, independent of state.
    function automatic logic [SEL_W-1:0] imm_src_f(input logic [OP_W-1:0] op);
        logic [SEL_W-1:0] imm;
        case (op)
            OP_LOAD, OP_ITYPE: imm = IMM_I;
            OP_STORE:          imm = IMM_S;
            OP_BRANCH:         imm = IMM_B;
            OP_JAL:            imm = IMM_J;
            default:           imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/mc_output_decoder.sv
// Maps the current controller state (plus Zero / Mem_ready qualifiers) to the datapath control word.
module mc_output_decoder
    import multi_cycle_controller_pkg::*;
(
    input  state_t i_state,
    input  logic   i_zero,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    ctrl_t w_ctrl;

    always_comb begin
        w_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                w_ctrl.mem_req    = 1'b1;
                w_ctrl.adr_src    = ADR_PC;
                w_ctrl.alu_src_a  = SRC_A_PC;
                w_ctrl.alu_src_b  = SRC_B_FOUR;
                w_ctrl.alu_op     = ALU_ADD;
                w_ctrl.result_src = RES_ALU_RESULT;
                w_ctrl.ir_write   = i_mem_ready;
                w_ctrl.pc_write   = i_mem_ready;
            end
            S_DECODE: begin
                w_ctrl.alu_src_a = SRC_A_OLD_PC;
                w_ctrl.alu_src_b = SRC_B_IMM;
                w_ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_ADR: begin
                w_ctrl.alu_src_a = SRC_A_RS1;
                w_ctrl.alu_src_b = SRC_B_IMM;
                w_ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.adr_src = ADR_ALU;
            end
            S_MEM_WB: begin
                w_ctrl.result_src = RES_READ_DATA;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                w_ctrl.mem_req    = 1'b1;
                w_ctrl.adr_src    = ADR_ALU;
                w_ctrl.result_src = RES_ALU_OUT;
                w_ctrl.mem_write  = i_mem_ready;
                w_ctrl.instr_done = i_mem_ready;
            end
            S_EXECUTE_R: begin
                w_ctrl.alu_src_a = SRC_A_RS1;
                w_ctrl.alu_src_b = SRC_B_RS2;
                w_ctrl.alu_op    = ALU_FUNCT;
            end
            S_EXECUTE_I: begin
                w_ctrl.alu_src_a = SRC_A_RS1;
                w_ctrl.alu_src_b = SRC_B_IMM;
                w_ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALU_WB: begin
                w_ctrl.result_src = RES_ALU_OUT;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            // Branch target was computed into ALU-out during DECODE; compare here.
            S_BEQ: begin
                w_ctrl.alu_src_a  = SRC_A_RS1;
                w_ctrl.alu_src_b  = SRC_B_RS2;
                w_ctrl.alu_op     = ALU_SUB;
                w_ctrl.result_src = RES_ALU_OUT;
                w_ctrl.pc_write   = i_zero;
                w_ctrl.instr_done = 1'b1;
            end
            S_JAL: begin
                w_ctrl.alu_src_a  = SRC_A_OLD_PC;
                w_ctrl.alu_src_b  = SRC_B_FOUR;
                w_ctrl.alu_op     = ALU_ADD;
                w_ctrl.result_src = RES_ALU_OUT;
                w_ctrl.pc_write   = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    assign o_ctrl = w_ctrl;

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle processor control FSM: state register, next-state logic and sticky illegal-opcode flag.
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    op,
    input  logic               Zero,
    input  logic               Mem_ready,
    output logic               Mem_req,
    output logic               Adr_src,
    output logic               IR_write,
    output logic               PC_write,
    output logic               Reg_write,
    output logic               Mem_write,
    output logic [SEL_W-1:0]   ALU_src_A,
    output logic [SEL_W-1:0]   ALU_src_B,
    output logic [SEL_W-1:0]   ALU_op,
    output logic [SEL_W-1:0]   Result_src,
    output logic [SEL_W-1:0]   Imm_src,
    output logic               Instr_done,
    output logic               Illegal_op,
    output logic [STATE_W-1:0] State
);

    state_t r_state;
    state_t w_next_state;
    logic   r_illegal;
    logic   w_set_illegal;
    ctrl_t  w_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state  = S_FETCH;
        w_set_illegal = 1'b0;
        case (r_state)
            S_FETCH:     w_next_state = Mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_next_state = S_MEM_ADR;
                    OP_RTYPE:          w_next_state = S_EXECUTE_R;
                    OP_ITYPE:          w_next_state = S_EXECUTE_I;
                    OP_BRANCH:         w_next_state = S_BEQ;
                    OP_JAL:            w_next_state = S_JAL;
                    default: begin
                        w_next_state  = S_FETCH;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADR:   w_next_state = (op == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  w_next_state = Mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    w_next_state = S_FETCH;
            S_MEM_WRITE: w_next_state = Mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE_R: w_next_state = S_ALU_WB;
            S_EXECUTE_I: w_next_state = S_ALU_WB;
            S_JAL:       w_next_state = S_ALU_WB;
            S_ALU_WB:    w_next_state = S_FETCH;
            S_BEQ:       w_next_state = S_FETCH;
            default:     w_next_state = S_FETCH;
        endcase
    end

    mc_output_decoder u_output_decoder (
        .i_state     (r_state),
        .i_zero      (Zero),
        .i_mem_ready (Mem_ready),
        .o_ctrl      (w_ctrl)
    );

    // Reset forces FETCH, which requests memory; gate requests and enables so nothing fires while held.
    assign Mem_req    = w_ctrl.mem_req    & rst_n;
    assign IR_write   = w_ctrl.ir_write   & rst_n;
    assign PC_write   = w_ctrl.pc_write   & rst_n;
    assign Reg_write  = w_ctrl.reg_write  & rst_n;
    assign Mem_write  = w_ctrl.mem_write  & rst_n;
    assign Instr_done = w_ctrl.instr_done & rst_n;

    assign Adr_src    = w_ctrl.adr_src;
    assign ALU_src_A  = w_ctrl.alu_src_a;
    assign ALU_src_B  = w_ctrl.alu_src_b;
    assign ALU_op     = w_ctrl.alu_op;
    assign Result_src = w_ctrl.result_src;
    assign Imm_src    = imm_src_f(op);
    assign Illegal_op = r_illegal;
    assign State      = r_state;

endmodule
